// File: rtl/imem_loader_pkg.sv
// imem_loader shared definitions.
// State encoding and checksum target.
package imem_loader_pkg;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [7:0] CHECKSUM_OK = 8'h00;
endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler.
// Owns lane counter, assembly word, byte mask and write strobe.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic        last_i,
  input  logic [7:0]  byte_i,
  output logic        launch_o,
  output logic        we_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o
);
  logic [1:0]  lane_q;
  logic [31:0] asm_q;
  logic [3:0]  mask_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] word_d;
  logic [3:0]  mask_d;
  logic        launch;

  // Merge the incoming byte into its lane; launch on lane 3 or last byte.
  always_comb begin
    word_d = asm_q | ({24'd0, byte_i} << {lane_q, 3'b000});
    mask_d = mask_q | (4'b0001 << lane_q);
    launch = push_i && ((lane_q == 2'd3) || last_i);
  end

  // Assembly word clears on launch so back-to-back bytes never stall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_q  <= '0;
      asm_q   <= '0;
      mask_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      we_q <= launch;
      if (launch) begin
        wdata_q <= word_d;
        be_q    <= mask_d;
      end else begin
        be_q <= '0;
      end
      if (clear_i || launch) begin
        lane_q <= '0;
        asm_q  <= '0;
        mask_q <= '0;
      end else if (push_i) begin
        lane_q <= lane_q + 2'd1;
        asm_q  <= word_d;
        mask_q <= mask_d;
      end
    end
  end

  assign launch_o = launch;
  assign we_o     = we_q;
  assign wdata_o  = wdata_q;
  assign be_o     = be_q;
endmodule

// File: rtl/imem_loader.sv
// Streamed program loader for instruction memory.
// Header length, payload words, then an 8-bit zero-sum checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_BYTES = 24,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_be_o,
  output logic                  cpu_hold_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);
  logic [2:0]            state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           len_q, len_d;
  logic [7:0]            sum_q, sum_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  hold_q, hold_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  ready, xfer, push, last, launch, clear;
  logic [31:0]           n_full;

  assign ready  = (state_q == S_LEN) || (state_q == S_DATA)
               || (state_q == S_CSUM);
  assign xfer   = ready && byte_valid_i;
  assign push   = xfer && (state_q == S_DATA);
  assign last   = (cnt_q + 32'd1) == len_q;
  assign n_full = {byte_i, len_q[23:0]};
  assign clear  = (state_d == S_LEN) && (state_q != S_LEN);

  imem_word_packer u_packer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (clear),
    .push_i   (push),
    .last_i   (last),
    .byte_i   (byte_i),
    .launch_o (launch),
    .we_o     (mem_we_o),
    .wdata_o  (mem_wdata_o),
    .be_o     (mem_be_o)
  );

  // Load sequencing: header, payload, checksum, verdict.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sum_d   = sum_q;
    done_d  = done_q;
    err_d   = err_q;
    hold_d  = hold_q;
    addr_d  = addr_q;
    if (launch) addr_d = ADDR_WIDTH'({cnt_q[31:2], 2'b00});
    case (state_q)
      S_LEN: begin
        if (xfer) begin
          len_d[8*cnt_q[1:0] +: 8] = byte_i;
          cnt_d = cnt_q + 32'd1;
          if (cnt_q[1:0] == 2'd3) begin
            cnt_d = '0;
            if (n_full > 32'(DEPTH_BYTES)) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else if (n_full == 32'd0) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          sum_d = sum_q + byte_i;
          cnt_d = cnt_q + 32'd1;
          if (last) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (xfer) begin
          if (8'(sum_q + byte_i) == CHECKSUM_OK) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        if (start_i) begin
          state_d = S_LEN;
          cnt_d   = '0;
          len_d   = '0;
          sum_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
        end
      end
    endcase
  end

  // Loader state registers; reset holds the CPU.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
    end
  end

  assign byte_ready_o = ready;
  assign busy_o       = ready;
  assign mem_addr_o   = addr_q;
  assign cpu_hold_o   = hold_q;
  assign done_o       = done_q;
  assign error_o      = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader.
// Logs memory writes and checks each load's outcome.
module tb_imem_loader;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        cpu_hold_o, busy_o, done_o, error_o;

  int checks = 0;
  int errors = 0;
  int be_bad = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [3:0]  wb[$];
  logic [7:0]  pl[$];

  imem_loader #(.DEPTH_BYTES(24), .ADDR_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o), .cpu_hold_o(cpu_hold_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (mem_we_o) begin
      wa.push_back(mem_addr_o);
      wd.push_back(mem_wdata_o);
      wb.push_back(mem_be_o);
    end else if (mem_be_o != 4'h0) begin
      be_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) begin
      @(negedge clk_i);
      byte_valid_i = 1'b0;
    end
    @(negedge clk_i);
    byte_i = b;
    byte_valid_i = 1'b1;
    while (!byte_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!byte_ready_o) chk("ready_timeout", 32'(byte_ready_o), 32'd1);
    @(posedge clk_i);
  endtask

  task automatic pulse_start();
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic load(input logic [31:0] n, input logic [7:0] cs,
                      input int maxgap, input int startat);
    wa.delete(); wd.delete(); wb.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send(n[8*i +: 8], 0);
    if (n <= 32'd24) begin
      for (int i = 0; i < int'(n); i++) begin
        if (i == startat) begin
          pulse_start();
          chk("busy_after_mid_start", 32'(busy_o), 32'd1);
        end
        send(pl[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
      end
      send(cs, 0);
    end
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic chk_w(input int k, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    if (wa.size() > k) begin
      chk($sformatf("waddr%0d", k), wa[k], a);
      chk($sformatf("wdata%0d", k), wd[k], d);
      chk($sformatf("wbe%0d", k), 32'(wb[k]), 32'(b));
    end else begin
      chk($sformatf("wmissing%0d", k), wa.size(), k + 1);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    chk("rst_hold", 32'(cpu_hold_o), 32'd1);
    chk("rst_ready", 32'(byte_ready_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_be", 32'(mem_be_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(error_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Payload sum is 0x60: 0x5B fails, 0xA0 closes to zero.
    pl = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    load(32'd8, 8'h5B, 0, -1);
    chk("t1bad_err", 32'(error_o), 32'd1);
    chk("t1bad_done", 32'(done_o), 32'd0);
    chk("t1bad_hold", 32'(cpu_hold_o), 32'd1);
    chk("t1bad_nw", wa.size(), 32'd2);
    load(32'd8, 8'hA0, 0, -1);
    chk("t1_nw", wa.size(), 32'd2);
    chk_w(0, 32'h0, 32'h00A00513, 4'hF);
    chk_w(1, 32'h4, 32'h00100593, 4'hF);
    chk("t1_done", 32'(done_o), 32'd1);
    chk("t1_err", 32'(error_o), 32'd0);
    chk("t1_hold", 32'(cpu_hold_o), 32'd0);
    chk("t1_busy", 32'(busy_o), 32'd0);

    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    load(32'd6, 8'hEB, 0, -1);
    chk("t2_nw", wa.size(), 32'd2);
    chk_w(0, 32'h0, 32'h04030201, 4'hF);
    chk_w(1, 32'h4, 32'h00000605, 4'h3);
    chk("t2_done", 32'(done_o), 32'd1);

    load(32'd0, 8'h00, 0, -1);
    chk("t3_nw", wa.size(), 32'd0);
    chk("t3_done", 32'(done_o), 32'd1);
    chk("t3_hold", 32'(cpu_hold_o), 32'd0);
    load(32'd0, 8'h01, 0, -1);
    chk("t3bad_err", 32'(error_o), 32'd1);
    chk("t3bad_done", 32'(done_o), 32'd0);
    chk("t3bad_hold", 32'(cpu_hold_o), 32'd1);

    load(32'd28, 8'h00, 0, -1);
    chk("t4_err", 32'(error_o), 32'd1);
    chk("t4_nw", wa.size(), 32'd0);
    chk("t4_ready", 32'(byte_ready_o), 32'd0);
    chk("t4_busy", 32'(busy_o), 32'd0);

    // Bytes 0x10..0x27 sum to 0x294, so 0x6C closes to zero.
    pl.delete();
    for (int i = 0; i < 24; i++) pl.push_back(8'(8'h10 + i));
    load(32'd24, 8'h6C, 2, 10);
    chk("t5_nw", wa.size(), 32'd6);
    for (int k = 0; k < 6; k++)
      chk_w(k, 32'(4 * k),
            {pl[4*k+3], pl[4*k+2], pl[4*k+1], pl[4*k]}, 4'hF);
    chk("t5_done", 32'(done_o), 32'd1);

    pl = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    pulse_start();
    for (int i = 0; i < 4; i++) send((i == 0) ? 8'h08 : 8'h00, 0);
    for (int i = 0; i < 5; i++) send(pl[i], 0);
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("t6_hold", 32'(cpu_hold_o), 32'd1);
    chk("t6_ready", 32'(byte_ready_o), 32'd0);
    chk("t6_we", 32'(mem_we_o), 32'd0);
    chk("t6_addr", mem_addr_o, 32'd0);
    chk("t6_wdata", mem_wdata_o, 32'd0);
    chk("t6_be", 32'(mem_be_o), 32'd0);
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_done", 32'(done_o), 32'd0);
    chk("t6_err", 32'(error_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    load(32'd8, 8'hA0, 0, -1);
    chk("t6_nw", wa.size(), 32'd2);
    chk_w(0, 32'h0, 32'h00A00513, 4'hF);
    chk_w(1, 32'h4, 32'h00100593, 4'hF);
    chk("t6_reload_done", 32'(done_o), 32'd1);
    chk("t6_reload_hold", 32'(cpu_hold_o), 32'd0);

    chk("be_when_idle", 32'(be_bad), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
